// File: rtl/decode_stage.sv
// RV64I/M decode and register-read stage: register file, immediate generation,
// load-use bubble, flush path, registered ID/EX outputs. Optional macro: DECODE_ILLEGAL_TRAP_EN.
module decode_stage #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned REG_COUNT      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  logic [BUS_DATA_WIDTH-1:0] pc,
    input  logic [31:0]               inIns,
    input  logic                      inStall,
    input  logic                      inFlush,
    input  logic                      wbRegWrite,
    input  logic [4:0]                wbDestRegister,
    input  logic [BUS_DATA_WIDTH-1:0] wbData,
    output logic                      outStallFetch,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] outPc,
    output logic [3:0]                outOpClass,
    output logic [4:0]                outAluOp,
    output logic [BUS_DATA_WIDTH-1:0] outReadData1,
    output logic [BUS_DATA_WIDTH-1:0] outReadData2,
    output logic [BUS_DATA_WIDTH-1:0] outImm,
    output logic [4:0]                outRegisterRs,
    output logic [4:0]                outRegisterRt,
    output logic [4:0]                outDestRegister,
    output logic                      outRegWrite,
    output logic                      outMemRead,
    output logic                      outMemWrite,
    output logic                      outMemOrReg,
    output logic                      outBranch,
    output logic                      outJump,
    output logic [2:0]                outLoadType,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                      outIllegal,
`endif
    output logic [1:0]                outStoreType
);

    localparam int unsigned W        = BUS_DATA_WIDTH;
    localparam bit          IS_RV64  = (BUS_DATA_WIDTH == 64);

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [3:0] CLS_OP        = 4'd1;
    localparam logic [3:0] CLS_OP_IMM    = 4'd2;
    localparam logic [3:0] CLS_OP_32     = 4'd3;
    localparam logic [3:0] CLS_OP_IMM_32 = 4'd4;
    localparam logic [3:0] CLS_LOAD      = 4'd5;
    localparam logic [3:0] CLS_STORE     = 4'd6;
    localparam logic [3:0] CLS_BRANCH    = 4'd7;
    localparam logic [3:0] CLS_JAL       = 4'd8;
    localparam logic [3:0] CLS_JALR      = 4'd9;
    localparam logic [3:0] CLS_LUI       = 4'd10;
    localparam logic [3:0] CLS_AUIPC     = 4'd11;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] pc;
        logic [3:0]   op_class;
        logic [4:0]   alu_op;
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] imm;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         mem_or_reg;
        logic         branch;
        logic         jump;
        logic [2:0]   load_type;
        logic [1:0]   store_type;
    } idex_t;

    idex_t        idex_q, idex_d, dec;
    logic [W-1:0] regs_q [REG_COUNT];
    logic [W-1:0] regs_d [REG_COUNT];

    logic [6:0]   opcode, funct7;
    logic [2:0]   funct3;
    logic [4:0]   rs1_idx, rs2_idx;
    logic [W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [W-1:0] rs1_data, rs2_data;
    logic         wb_en, shift_lo_ok, shift_ok;
    logic         use_rs1, use_rs2, use_rd, is_imm_alu, known, reserved, legal;
    logic         hazard;

    assign opcode  = inIns[6:0];
    assign funct3  = inIns[14:12];
    assign funct7  = inIns[31:25];
    assign rs1_idx = inIns[19:15];
    assign rs2_idx = inIns[24:20];

    assign imm_i = W'($signed(inIns[31:20]));
    assign imm_s = W'($signed({inIns[31:25], inIns[11:7]}));
    assign imm_b = W'($signed({inIns[31], inIns[7], inIns[30:25], inIns[11:8], 1'b0}));
    assign imm_u = W'($signed({inIns[31:12], 12'b0}));
    assign imm_j = W'($signed({inIns[31], inIns[19:12], inIns[20], inIns[30:21], 1'b0}));

    // Shift-immediate encodings: shamt[5] only exists on RV64.
    assign shift_lo_ok = (inIns[31:26] == 6'b000000) && (IS_RV64 || !inIns[25]);
    assign shift_ok    = ((inIns[31:26] == 6'b000000) || (inIns[31:26] == 6'b010000))
                         && (IS_RV64 || !inIns[25]);

    assign wb_en = wbRegWrite && (wbDestRegister != 5'd0) && (32'(wbDestRegister) < REG_COUNT);

    // Write-first read ports; x0 and out-of-range indices read as zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if ((rs1_idx != 5'd0) && (32'(rs1_idx) < REG_COUNT))
            rs1_data = (wb_en && (wbDestRegister == rs1_idx)) ? wbData : regs_q[rs1_idx];
        if ((rs2_idx != 5'd0) && (32'(rs2_idx) < REG_COUNT))
            rs2_data = (wb_en && (wbDestRegister == rs2_idx)) ? wbData : regs_q[rs2_idx];
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_en) regs_d[wbDestRegister] = wbData;
    end

    always_comb begin
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        use_rd     = 1'b0;
        is_imm_alu = 1'b0;
        known      = 1'b1;
        reserved   = 1'b0;
        imm        = '0;
        case (opcode)
            OPC_OP: begin
                dec.op_class  = CLS_OP;
                dec.reg_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                case (funct7)
                    7'b0000000, 7'b0000001: reserved = 1'b0;
                    7'b0100000: reserved = !(funct3 inside {3'b000, 3'b101});
                    default:    reserved = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.op_class  = CLS_OP_IMM;
                dec.reg_write = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1; is_imm_alu = 1'b1;
                imm = imm_i;
                if (funct3 == 3'b001)      reserved = !shift_lo_ok;
                else if (funct3 == 3'b101) reserved = !shift_ok;
            end
            OPC_OP_32: begin
                known         = IS_RV64;
                dec.op_class  = CLS_OP_32;
                dec.reg_write = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                case (funct7)
                    7'b0000000: reserved = !(funct3 inside {3'b000, 3'b001, 3'b101});
                    7'b0100000: reserved = !(funct3 inside {3'b000, 3'b101});
                    7'b0000001: reserved = funct3 inside {3'b001, 3'b010, 3'b011};
                    default:    reserved = 1'b1;
                endcase
            end
            OPC_OP_IMM_32: begin
                known         = IS_RV64;
                dec.op_class  = CLS_OP_IMM_32;
                dec.reg_write = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1; is_imm_alu = 1'b1;
                imm = imm_i;
                case (funct3)
                    3'b000:  reserved = 1'b0;
                    3'b001:  reserved = (funct7 != 7'b0000000);
                    3'b101:  reserved = !(funct7 inside {7'b0000000, 7'b0100000});
                    default: reserved = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.op_class   = CLS_LOAD;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_or_reg = 1'b1;
                dec.load_type  = funct3;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm = imm_i;
                reserved = (funct3 == 3'b111) || (!IS_RV64 && (funct3 inside {3'b011, 3'b110}));
            end
            OPC_STORE: begin
                dec.op_class   = CLS_STORE;
                dec.mem_write  = 1'b1;
                dec.store_type = funct3[1:0];
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm = imm_s;
                reserved = funct3[2] || (!IS_RV64 && (funct3 == 3'b011));
            end
            OPC_BRANCH: begin
                dec.op_class = CLS_BRANCH;
                dec.branch   = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm = imm_b;
                reserved = funct3 inside {3'b010, 3'b011};
            end
            OPC_JAL: begin
                dec.op_class  = CLS_JAL;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                use_rd = 1'b1;
                imm = imm_j;
            end
            OPC_JALR: begin
                dec.op_class  = CLS_JALR;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm = imm_i;
                reserved = (funct3 != 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.op_class  = (opcode == OPC_LUI) ? CLS_LUI : CLS_AUIPC;
                dec.reg_write = 1'b1;
                use_rd = 1'b1;
                imm = imm_u;
            end
            default: known = 1'b0;
        endcase

        legal = known && !reserved;
        if (legal) begin
            dec.valid  = 1'b1;
            dec.pc     = pc;
            dec.alu_op = is_imm_alu ? {(funct3 == 3'b101) && inIns[30], 1'b0, funct3}
                                    : {inIns[30], inIns[25], funct3};
            dec.rs1    = use_rs1 ? rs1_idx : 5'd0;
            dec.rs2    = use_rs2 ? rs2_idx : 5'd0;
            dec.rd     = use_rd ? inIns[11:7] : 5'd0;
            dec.rd1    = use_rs1 ? rs1_data : '0;
            dec.rd2    = use_rs2 ? rs2_data : '0;
            dec.imm    = imm;
        end else begin
            dec     = '0;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    // Load in ID/EX feeding a source of the instruction being decoded.
    assign hazard = idex_q.valid && idex_q.mem_read && inValid && (idex_q.rd != 5'd0)
                    && ((use_rs1 && (rs1_idx == idex_q.rd)) || (use_rs2 && (rs2_idx == idex_q.rd)));

    assign outStallFetch = inStall || (!inFlush && hazard);

    always_comb begin
        idex_d = idex_q;
        if (!inStall) begin
            if (inFlush || hazard || !inValid) idex_d = '0;
            else                               idex_d = dec;
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (!inFlush && !hazard && inValid && !legal) begin
                idex_d.valid = 1'b1;
                idex_d.pc    = pc;
            end
`endif
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (!inStall) illegal_d = !inFlush && !hazard && inValid && !legal;
    end

    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end

    assign outIllegal = illegal_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
            regs_q <= '{default: '0};
        end else begin
            idex_q <= idex_d;
            regs_q <= regs_d;
        end
    end

    assign outValid        = idex_q.valid;
    assign outPc           = idex_q.pc;
    assign outOpClass      = idex_q.op_class;
    assign outAluOp        = idex_q.alu_op;
    assign outReadData1    = idex_q.rd1;
    assign outReadData2    = idex_q.rd2;
    assign outImm          = idex_q.imm;
    assign outRegisterRs   = idex_q.rs1;
    assign outRegisterRt   = idex_q.rs2;
    assign outDestRegister = idex_q.rd;
    assign outRegWrite     = idex_q.reg_write;
    assign outMemRead      = idex_q.mem_read;
    assign outMemWrite     = idex_q.mem_write;
    assign outMemOrReg     = idex_q.mem_or_reg;
    assign outBranch       = idex_q.branch;
    assign outJump         = idex_q.jump;
    assign outLoadType     = idex_q.load_type;
    assign outStoreType    = idex_q.store_type;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default 64-bit configuration).
module tb_decode_stage;

    localparam int unsigned W = 64;

    localparam logic [31:0] ADD_X1_X3_X3  = 32'h003180B3;
    localparam logic [31:0] ADDI_X2_X7_M1 = 32'hFFF38113;
    localparam logic [31:0] LD_X4_8_X1    = 32'h0080B203;
    localparam logic [31:0] ADD_X5_X4_X0  = 32'h000202B3;
    localparam logic [31:0] LD_X0_8_X1    = 32'h0080B003;
    localparam logic [31:0] ADD_X5_X0_X0  = 32'h000002B3;
    localparam logic [31:0] ADD_X6_X0_X0  = 32'h00000333;
    localparam logic [31:0] BEQ_X1_X2_M4  = 32'hFE208EE3;
    localparam logic [31:0] JAL_X1_8      = 32'h008000EF;
    localparam logic [31:0] LUI_X10       = 32'h80000537;
    localparam logic [31:0] SD_X3_16_X2   = 32'h00313823;
    localparam logic [31:0] ADD_X1_X5_X5  = 32'h005280B3;
    localparam logic [31:0] UNKNOWN_OPC   = 32'h0000007F;

    logic         clk, reset, in_valid, in_stall, in_flush, wb_reg_write;
    logic [W-1:0] pc_i, wb_data;
    logic [31:0]  in_ins;
    logic [4:0]   wb_dest;
    logic         out_stall_fetch, out_valid, out_reg_write, out_mem_read, out_mem_write;
    logic         out_mem_or_reg, out_branch, out_jump;
    logic [W-1:0] out_pc, out_rd1, out_rd2, out_imm;
    logic [3:0]   out_op_class;
    logic [4:0]   out_alu_op, out_rs, out_rt, out_rd;
    logic [2:0]   out_load_type;
    logic [1:0]   out_store_type;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic         out_illegal;
`endif

    int checks = 0;
    int errors = 0;

    decode_stage #(.BUS_DATA_WIDTH(W), .REG_COUNT(32)) dut (
        .clk(clk),
        .reset(reset),
        .inValid(in_valid),
        .pc(pc_i),
        .inIns(in_ins),
        .inStall(in_stall),
        .inFlush(in_flush),
        .wbRegWrite(wb_reg_write),
        .wbDestRegister(wb_dest),
        .wbData(wb_data),
        .outStallFetch(out_stall_fetch),
        .outValid(out_valid),
        .outPc(out_pc),
        .outOpClass(out_op_class),
        .outAluOp(out_alu_op),
        .outReadData1(out_rd1),
        .outReadData2(out_rd2),
        .outImm(out_imm),
        .outRegisterRs(out_rs),
        .outRegisterRt(out_rt),
        .outDestRegister(out_rd),
        .outRegWrite(out_reg_write),
        .outMemRead(out_mem_read),
        .outMemWrite(out_mem_write),
        .outMemOrReg(out_mem_or_reg),
        .outBranch(out_branch),
        .outJump(out_jump),
        .outLoadType(out_load_type),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .outIllegal(out_illegal),
`endif
        .outStoreType(out_store_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] p, input logic [31:0] ins);
        in_valid = 1'b1;
        pc_i     = p;
        in_ins   = ins;
    endtask

    initial begin
        reset = 1'b1; in_stall = 1'b0; in_flush = 1'b0;
        wb_reg_write = 1'b0; wb_dest = 5'd0; wb_data = '0;
        issue(64'h80, ADD_X1_X3_X3);
        tick(); tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_regwrite", 64'(out_reg_write), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        reset = 1'b0;

        // x3 <= 0x1234 while fetch is idle
        in_valid = 1'b0; wb_reg_write = 1'b1; wb_dest = 5'd3; wb_data = 64'h1234;
        tick();
        check("idle_bubble", 64'(out_valid), 64'd0);
        wb_reg_write = 1'b0;

        issue(64'h100, ADD_X1_X3_X3);
        tick();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_pc", out_pc, 64'h100);
        check("add_class", 64'(out_op_class), 64'd1);
        check("add_aluop", 64'(out_alu_op), 64'd0);
        check("add_rd1", out_rd1, 64'h1234);
        check("add_rd2", out_rd2, 64'h1234);
        check("add_rd", 64'(out_rd), 64'd1);
        check("add_rs", 64'(out_rs), 64'd3);
        check("add_regwrite", 64'(out_reg_write), 64'd1);

        // Same-cycle writeback forwarded into the read
        wb_reg_write = 1'b1; wb_dest = 5'd7; wb_data = 64'hDEAD;
        issue(64'h104, ADDI_X2_X7_M1);
        tick();
        wb_reg_write = 1'b0;
        check("addi_rd1", out_rd1, 64'hDEAD);
        check("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_class", 64'(out_op_class), 64'd2);
        check("addi_rt", 64'(out_rt), 64'd0);
        check("addi_rd2", out_rd2, 64'd0);

        issue(64'h108, LD_X4_8_X1);
        #1 check("ld_nostall", 64'(out_stall_fetch), 64'd0);
        tick();
        check("ld_class", 64'(out_op_class), 64'd5);
        check("ld_memread", 64'(out_mem_read), 64'd1);
        check("ld_memorreg", 64'(out_mem_or_reg), 64'd1);
        check("ld_type", 64'(out_load_type), 64'd3);
        check("ld_imm", out_imm, 64'd8);
        check("ld_rd", 64'(out_rd), 64'd4);

        issue(64'h10C, ADD_X5_X4_X0);
        #1 check("hz_stall", 64'(out_stall_fetch), 64'd1);
        tick();
        check("hz_bubble_valid", 64'(out_valid), 64'd0);
        check("hz_bubble_memread", 64'(out_mem_read), 64'd0);
        check("hz_release", 64'(out_stall_fetch), 64'd0);
        tick();
        check("hz_issue_valid", 64'(out_valid), 64'd1);
        check("hz_issue_pc", out_pc, 64'h10C);
        check("hz_issue_rs", 64'(out_rs), 64'd4);
        check("hz_issue_rd", 64'(out_rd), 64'd5);

        // A load targeting x0 never stalls, even for a reader of x0
        issue(64'h110, LD_X0_8_X1);
        tick();
        check("ldx0_valid", 64'(out_valid), 64'd1);
        check("ldx0_rd", 64'(out_rd), 64'd0);
        issue(64'h114, ADD_X5_X0_X0);
        #1 check("ldx0_nostall", 64'(out_stall_fetch), 64'd0);
        tick();
        check("ldx0_next_valid", 64'(out_valid), 64'd1);
        check("ldx0_next_pc", out_pc, 64'h114);

        issue(64'h118, ADDI_X2_X7_M1);
        tick();
        check("pre_stall_rd1", out_rd1, 64'hDEAD);
        in_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       issue(64'h200, ADD_X1_X3_X3);
                1:       issue(64'h204, BEQ_X1_X2_M4);
                default: issue(64'h208, LD_X4_8_X1);
            endcase
            #1 check("stall_fetch", 64'(out_stall_fetch), 64'd1);
            tick();
            check("stall_pc", out_pc, 64'h118);
            check("stall_class", 64'(out_op_class), 64'd2);
        end
        in_stall = 1'b0;

        in_flush = 1'b1;
        issue(64'h20C, ADD_X1_X3_X3);
        #1 check("flush_nostall", 64'(out_stall_fetch), 64'd0);
        tick();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_regwrite", 64'(out_reg_write), 64'd0);
        in_flush = 1'b0;

        issue(64'h300, BEQ_X1_X2_M4);
        tick();
        check("beq_branch", 64'(out_branch), 64'd1);
        check("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_class", 64'(out_op_class), 64'd7);
        check("beq_aluop", 64'(out_alu_op), 64'd24);
        check("beq_rs_rt", 64'({out_rs, out_rt}), 64'({5'd1, 5'd2}));
        check("beq_rd", 64'(out_rd), 64'd0);
        check("beq_regwrite", 64'(out_reg_write), 64'd0);

        wb_reg_write = 1'b1; wb_dest = 5'd0; wb_data = 64'hFFFF;
        issue(64'h304, ADD_X6_X0_X0);
        tick();
        wb_reg_write = 1'b0;
        check("x0_same_cycle", out_rd1, 64'd0);
        tick();
        check("x0_after_write", out_rd1, 64'd0);

        issue(64'h308, JAL_X1_8);
        tick();
        check("jal_class", 64'(out_op_class), 64'd8);
        check("jal_jump", 64'(out_jump), 64'd1);
        check("jal_imm", out_imm, 64'd8);
        check("jal_regwrite", 64'(out_reg_write), 64'd1);

        issue(64'h30C, LUI_X10);
        tick();
        check("lui_class", 64'(out_op_class), 64'd10);
        check("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lui_rd", 64'(out_rd), 64'd10);

        issue(64'h310, SD_X3_16_X2);
        tick();
        check("sd_memwrite", 64'(out_mem_write), 64'd1);
        check("sd_type", 64'(out_store_type), 64'd3);
        check("sd_imm", out_imm, 64'd16);
        check("sd_rd2", out_rd2, 64'h1234);
        check("sd_rd", 64'(out_rd), 64'd0);

        issue(64'h314, UNKNOWN_OPC);
        tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("unk_valid", 64'(out_valid), 64'd1);
        check("unk_illegal", 64'(out_illegal), 64'd1);
`else
        check("unk_valid", 64'(out_valid), 64'd0);
`endif
        check("unk_regwrite", 64'(out_reg_write), 64'd0);

        // Mid-stream reset clears the file as well as ID/EX
        in_valid = 1'b0; wb_reg_write = 1'b1; wb_dest = 5'd5; wb_data = 64'h55;
        tick();
        wb_reg_write = 1'b0;
        reset = 1'b1;
        issue(64'h400, ADD_X1_X5_X5);
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_pc", out_pc, 64'd0);
        check("mid_rst_class", 64'(out_op_class), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_x5", out_rd1, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
